debug_rf_scanner: RTL and testbench
===================================

Name: debug_rf_scanner

Overview:
- Debug-side reader for the processor's register-file debug port (rf_ra / rf_rd) on system_debug.
- On a trigger, walks register indices 0..NUM_REGS-1 and captures each value.
- Streams each value as an {index, data} beat over a valid/ready handshake and accumulates a running checksum.
- Gives benches and on-chip debug logic a way to read architectural state without hierarchical references into the datapath.

Parameters:
- NUM_REGS, 32: number of registers scanned, indices 0..NUM_REGS-1.
- RA_WIDTH, 5: width of rf_ra and out_index.
- DATA_WIDTH, 32: width of rf_rd, out_data and checksum.
- READ_LATENCY, 0: extra wait cycles after rf_ra is driven before rf_rd is sampled, legal 0..3.
- HALT_INSTR, 32'h0800_0033: halt encoding used by the optional feature.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  scan request, sampled in IDLE only.
- instruction  in  32  current fetched instruction; used only with DEBUG_HALT_DETECT_EN.
- rf_ra  out  RA_WIDTH  register-file debug read address, registered.
- rf_rd  in  DATA_WIDTH  register-file debug read data, combinational from rf_ra.
- out_valid  out  1  beat valid.
- out_ready  in  1  sink accepts beat.
- out_index  out  RA_WIDTH  register index of the current beat.
- out_data  out  DATA_WIDTH  register value of the current beat.
- busy  out  1  scan in progress (any state other than IDLE).
- done  out  1  one-cycle pulse after the last beat is accepted.
- checksum  out  DATA_WIDTH  mod-2^DATA_WIDTH sum of all accepted out_data in the current or last scan.
- instr_count  out  16  cycles since reset until halt; tied to 0 without the optional feature.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; rf_ra, out_valid, out_index, out_data, busy, done, checksum and instr_count all 0.
- Reset mid-scan aborts immediately; no beat is completed after reset asserts.
- FSM states: IDLE, ADDR, WAIT, OUT, DONE.
- IDLE: start=1 at an edge -> ADDR, with idx=0 and checksum cleared to 0.
- IDLE: start in any other state is ignored; it is not queued.
- ADDR (1 cycle): rf_ra <= idx; wcnt <= READ_LATENCY; -> WAIT.
- WAIT: if wcnt==0, then out_data <= rf_rd, out_index <= idx, out_valid <= 1, and -> OUT. Otherwise wcnt decrements and the FSM stays in WAIT.
- OUT: out_valid, out_index and out_data are held stable until out_valid & out_ready at an edge.
- OUT, on handshake: out_valid <= 0 and checksum <= checksum + out_data (wrap-around).
- OUT, on handshake: if idx==NUM_REGS-1 -> DONE; else idx <= idx+1 and -> ADDR.
- DONE (1 cycle): done=1; -> IDLE. Checksum holds until the next start.
- Timing with out_ready held 1: start sampled at edge E0 puts the FSM in ADDR for cycle 1.
  - Each register takes 3+READ_LATENCY cycles.
  - The last handshake occurs in cycle NUM_REGS*(3+READ_LATENCY).
  - done is asserted in the following cycle.
- rf_ra holds its last value while in IDLE. Register 0 is scanned like any other index; no special-casing.
- start asserted in the same cycle as done: ignored, because the FSM is in DONE, not IDLE.

Optional Feature:
- Macro: DEBUG_HALT_DETECT_EN.
- With the macro defined:
  - instr_count increments every cycle after reset, saturating at 16'hFFFF, and freezes when instruction==HALT_INSTR is first seen.
  - That first halt, if it occurs while in IDLE, starts a scan exactly as start=1 would.
  - A one-shot latch prevents re-triggering on later halt instructions until the next reset.
  - start still works independently.
- Without the macro: instruction is ignored, instr_count is constant 0, and only start triggers a scan.

Test Plan:
- Reset: assert reset_n=0 asynchronously mid-cycle -> every output reads 0 immediately, with no clock edge required.
- Basic scan: rf model reg[i]=3*i, READ_LATENCY=0, out_ready=1, start pulsed at E0 -> 32 beats, index 0..31 with data 0..93 in order. Checksum must equal 0x5D0 and done must pulse in cycle 97 only, with busy low in cycle 98.
- Backpressure: out_ready=0 for 5 cycles while index 4 is presented -> out_valid, out_index=4 and out_data=12 stay stable. No index is skipped or duplicated; final checksum is still 0x5D0.
- Latency: READ_LATENCY=2, same model -> rf_ra changes 5 cycles apart; done in cycle 161; beats identical to the basic scan.
- Abort/restart: start pulsed again mid-scan -> ignored. Then reset_n=0 while index 10 is in OUT -> all outputs 0. A new start rescans from index 0 and checksum ends at 0x5D0.
- Halt (macro on): drive instruction=32'h0800_0033 in cycle 53 after reset release -> instr_count=53 and a scan auto-starts. A second halt after done causes no new scan.

Source files
------------

// File: rtl/debug_rf_scanner_if.sv
// ---------------------------------------------------------------------------
// debug_rf_scanner_if
//   Bus bundle between the register-file scanner and its surroundings.
//   - rf_ra / rf_rd : debug read port into the register file
//                     (rf_rd is combinational from rf_ra).
//   - out_valid / out_ready / out_index / out_data : {index, data} beat stream.
//   Modports:
//     master : scanner side (drives rf_ra and the beat stream).
//     slave  : register file and sink side.
// ---------------------------------------------------------------------------
interface debug_rf_scanner_if #(
    parameter int RA_WIDTH   = 5,
    parameter int DATA_WIDTH = 32
) ();
    logic [RA_WIDTH-1:0]   rf_ra;
    logic [DATA_WIDTH-1:0] rf_rd;
    logic                  out_valid;
    logic                  out_ready;
    logic [RA_WIDTH-1:0]   out_index;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output rf_ra,
        input  rf_rd,
        output out_valid,
        input  out_ready,
        output out_index,
        output out_data
    );

    modport slave (
        input  rf_ra,
        output rf_rd,
        input  out_valid,
        output out_ready,
        input  out_index,
        input  out_data
    );
endinterface

// File: rtl/debug_rf_scanner.sv
// ---------------------------------------------------------------------------
// debug_rf_scanner
//   On a trigger, walks register indices 0..NUM_REGS-1 through the register
//   file debug port, streams each value as an {index, data} beat on a
//   valid/ready handshake and keeps a wrap-around checksum of accepted beats.
//
//   Ports:
//     clock        : single clock, rising edge
//     reset_n      : asynchronous, active-low reset
//     start        : scan request, honoured only in IDLE
//     instruction  : fetched instruction (used only with halt detection)
//     bus          : debug_rf_scanner_if.master (rf_ra/rf_rd, beat stream)
//     busy         : high in any state other than IDLE
//     done         : one-cycle pulse after the last beat is accepted
//     checksum     : sum of accepted out_data for the current/last scan
//     instr_count  : cycles since reset until halt (0 without halt detection)
//
//   Optional feature (macro DEBUG_HALT_DETECT_EN):
//     instr_count counts cycles from reset, saturating, and freezes on the
//     first instruction==HALT_INSTR. That first halt also starts a scan if
//     the scanner is idle. A one-shot latch ignores later halts until reset.
// ---------------------------------------------------------------------------
module debug_rf_scanner #(
    parameter int          NUM_REGS     = 32,
    parameter int          RA_WIDTH     = 5,
    parameter int          DATA_WIDTH   = 32,
    parameter int          READ_LATENCY = 0,
    parameter logic [31:0] HALT_INSTR   = 32'h0800_0033
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [31:0]               instruction,
    debug_rf_scanner_if.master        bus,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     checksum,
    output logic [15:0]               instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [RA_WIDTH-1:0] LAST_IDX = RA_WIDTH'(NUM_REGS - 1);
    localparam logic [1:0]          WAIT_LD  = 2'(READ_LATENCY);

    state_t                state_q, state_d;
    logic [RA_WIDTH-1:0]   idx_q, idx_d;
    logic [1:0]            wcnt_q, wcnt_d;
    logic [RA_WIDTH-1:0]   rf_ra_q, rf_ra_d;
    logic                  out_valid_q, out_valid_d;
    logic [RA_WIDTH-1:0]   out_index_q, out_index_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
    logic                  scan_trigger;

`ifdef DEBUG_HALT_DETECT_EN
    logic        halt_seen_q;
    logic [15:0] instr_count_q;
    logic        halt_hit;

    // Only the first halt after reset counts; later ones are masked.
    assign halt_hit = (instruction == HALT_INSTR) && !halt_seen_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            halt_seen_q   <= 1'b0;
            instr_count_q <= 16'd0;
        end else begin
            if (halt_hit) begin
                halt_seen_q <= 1'b1;
            end
            // Freeze on the halt cycle itself so the count equals the
            // number of cycles run before the halt was fetched.
            if (!halt_seen_q && !halt_hit && (instr_count_q != 16'hFFFF)) begin
                instr_count_q <= instr_count_q + 16'd1;
            end
        end
    end

    assign scan_trigger = start | halt_hit;
    assign instr_count  = instr_count_q;
`else
    logic unused_instruction;
    assign unused_instruction = &{1'b0, instruction};
    assign scan_trigger       = start;
    assign instr_count        = 16'd0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            wcnt_q      <= '0;
            rf_ra_q     <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            rf_ra_q     <= rf_ra_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            checksum_q  <= checksum_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        rf_ra_d     = rf_ra_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        checksum_d  = checksum_q;

        case (state_q)
            S_IDLE: begin
                if (scan_trigger) begin
                    state_d    = S_ADDR;
                    idx_d      = '0;
                    checksum_d = '0;
                end
            end
            S_ADDR: begin
                rf_ra_d = idx_q;
                wcnt_d  = WAIT_LD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // rf_ra has been stable for wcnt+1 cycles when wcnt reaches 0.
                if (wcnt_q == 2'd0) begin
                    out_data_d  = bus.rf_rd;
                    out_index_d = idx_q;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    wcnt_d = wcnt_q - 2'd1;
                end
            end
            S_OUT: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    checksum_d  = checksum_q + out_data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rf_ra     = rf_ra_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_index = out_index_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign checksum      = checksum_q;

endmodule

// File: tb/tb_debug_rf_scanner.sv
// ---------------------------------------------------------------------------
// tb_debug_rf_scanner
//   Two scanners (READ_LATENCY 0 and 2) share clock and reset. Each reads a
//   register-file model reg[i] = 3*i. Expected beats are queued when a scan
//   is launched; a monitor per instance pops and compares on every handshake
//   and checks that a stalled beat stays stable.
// ---------------------------------------------------------------------------
module tb_debug_rf_scanner;

    localparam logic [31:0] HALT = 32'h0800_0033;

    typedef logic [36:0] beat_t;

    logic        clock       = 1'b0;
    logic        reset_n     = 1'b1;
    logic        start_a     = 1'b0;
    logic        start_b     = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic [31:0] instr_b     = 32'd0;

    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] checksum_a, checksum_b;
    logic [15:0] instr_count_a, instr_count_b;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t qa[$];
    beat_t qb[$];

    always #5 clock = ~clock;

    debug_rf_scanner_if #(.RA_WIDTH(5), .DATA_WIDTH(32)) ifa ();
    debug_rf_scanner_if #(.RA_WIDTH(5), .DATA_WIDTH(32)) ifb ();

    // Register-file model: reg[i] = 3*i, combinational from rf_ra.
    assign ifa.rf_rd = 32'(ifa.rf_ra) * 32'd3;
    assign ifb.rf_rd = 32'(ifb.rf_ra) * 32'd3;

    debug_rf_scanner #(
        .NUM_REGS(32), .RA_WIDTH(5), .DATA_WIDTH(32),
        .READ_LATENCY(0), .HALT_INSTR(HALT)
    ) dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start_a),
        .instruction (instruction),
        .bus         (ifa),
        .busy        (busy_a),
        .done        (done_a),
        .checksum    (checksum_a),
        .instr_count (instr_count_a)
    );

    debug_rf_scanner #(
        .NUM_REGS(32), .RA_WIDTH(5), .DATA_WIDTH(32),
        .READ_LATENCY(2), .HALT_INSTR(HALT)
    ) dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start_b),
        .instruction (instr_b),
        .bus         (ifb),
        .busy        (busy_b),
        .done        (done_b),
        .checksum    (checksum_b),
        .instr_count (instr_count_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_scan(input int which);
        for (int i = 0; i < 32; i++) begin
            beat_t b;
            b = {5'(i), 32'(3 * i)};
            if (which == 0) qa.push_back(b);
            else            qb.push_back(b);
        end
    endtask

    task automatic pulse_start_a();
        @(posedge clock);
        #1 start_a = 1'b1;
        @(posedge clock);
        #1 start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clock);
            if (done_a) seen = 1'b1;
        end
        chk(name, seen, 1'b1);
    endtask

    // Waits (bounded) until instance A presents the given index, then drops
    // out_ready in the same cycle so that beat is not accepted.
    task automatic stall_at_a(input string name, input logic [4:0] idx);
        logic found;
        found = 1'b0;
        for (int t = 0; t < 400 && !found; t++) begin
            @(posedge clock);
            #1;
            if (ifa.out_valid && ifa.out_index == idx) begin
                found         = 1'b1;
                ifa.out_ready = 1'b0;
            end
        end
        chk(name, found, 1'b1);
    endtask

    // ---------------- monitors / scoreboard ----------------
    logic  held_a = 1'b0;
    beat_t held_val_a;
    always @(negedge clock) begin
        beat_t e;
        if (!reset_n) begin
            held_a = 1'b0;
        end else begin
            if (held_a)
                chk("a_stall_hold", {ifa.out_valid, ifa.out_index, ifa.out_data}, {1'b1, held_val_a});
            if (ifa.out_valid && ifa.out_ready) begin
                $display("beat a idx=%0d data=0x%0h", ifa.out_index, ifa.out_data);
                if (qa.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL a_unexpected_beat: got idx=%0d data=0x%0h, required no beat",
                             ifa.out_index, ifa.out_data);
                end else begin
                    e = qa.pop_front();
                    chk("a_beat", {ifa.out_index, ifa.out_data}, e);
                end
            end
            held_a     = ifa.out_valid && !ifa.out_ready;
            held_val_a = {ifa.out_index, ifa.out_data};
        end
    end

    always @(negedge clock) begin
        beat_t e;
        if (reset_n && ifb.out_valid && ifb.out_ready) begin
            $display("beat b idx=%0d data=0x%0h", ifb.out_index, ifb.out_data);
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_beat: got idx=%0d data=0x%0h, required no beat",
                         ifb.out_index, ifb.out_data);
            end else begin
                e = qb.pop_front();
                chk("b_beat", {ifb.out_index, ifb.out_data}, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int          done_cnt_a, done_cnt_b, last_chg;
        logic [4:0]  last_ra;

        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;

        // Reset asserted between edges; outputs must clear without a clock.
        #1 reset_n = 1'b0;
        #2;
        chk("rst_rf_ra",       ifa.rf_ra,     0);
        chk("rst_out_valid",   ifa.out_valid, 0);
        chk("rst_out_index",   ifa.out_index, 0);
        chk("rst_out_data",    ifa.out_data,  0);
        chk("rst_busy",        busy_a,        0);
        chk("rst_done",        done_a,        0);
        chk("rst_checksum",    checksum_a,    0);
        chk("rst_instr_count", instr_count_a, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // ---- basic scan (A) and latency-2 scan (B) launched together ----
        push_scan(0);
        push_scan(1);
        @(posedge clock);
        #1 start_a = 1'b1;
        start_b = 1'b1;
        @(posedge clock);   // E0
        #1 start_a = 1'b0;
        start_b = 1'b0;
        done_cnt_a = 0;
        done_cnt_b = 0;
        last_chg   = 0;
        last_ra    = ifb.rf_ra;
        for (int k = 1; k <= 162; k++) begin
            @(negedge clock);
            if (done_a) begin
                done_cnt_a++;
                chk("a_done_cycle", k, 97);
            end
            if (done_b) begin
                done_cnt_b++;
                chk("b_done_cycle", k, 161);
            end
            if (k == 96)  chk("a_busy_c96",  busy_a, 1);
            if (k == 98)  chk("a_busy_c98",  busy_a, 0);
            if (k == 162) chk("b_busy_c162", busy_b, 0);
            if (ifb.rf_ra !== last_ra) begin
                if (last_chg != 0) chk("b_ra_spacing", k - last_chg, 5);
                last_chg = k;
                last_ra  = ifb.rf_ra;
            end
            // Mid-scan start and start during DONE must both be ignored.
            if (k == 40) start_a = 1'b1;
            if (k == 41) start_a = 1'b0;
            if (k == 97) start_a = 1'b1;
            if (k == 98) start_a = 1'b0;
        end
        chk("a_done_pulses",  done_cnt_a, 1);
        chk("b_done_pulses",  done_cnt_b, 1);
        chk("a_checksum",     checksum_a, 32'h5D0);
        chk("b_checksum",     checksum_b, 32'h5D0);
        chk("a_queue_empty",  qa.size(),  0);
        chk("b_queue_empty",  qb.size(),  0);
        chk("a_idle_after",   busy_a,     0);

        // ---- backpressure on index 4 ----
        push_scan(0);
        pulse_start_a();
        stall_at_a("bp_found_idx4", 5'd4);
        repeat (5) @(posedge clock);
        #1;
        chk("bp_valid", ifa.out_valid, 1);
        chk("bp_index", ifa.out_index, 4);
        chk("bp_data",  ifa.out_data,  12);
        ifa.out_ready = 1'b1;
        wait_done_a("bp_done_seen");
        chk("bp_checksum",    checksum_a, 32'h5D0);
        chk("bp_queue_empty", qa.size(),  0);

        // ---- abort by reset while index 10 is held in OUT ----
        push_scan(0);
        pulse_start_a();
        stall_at_a("abort_found_idx10", 5'd10);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_rf_ra",     ifa.rf_ra,     0);
        chk("abort_out_valid", ifa.out_valid, 0);
        chk("abort_out_index", ifa.out_index, 0);
        chk("abort_out_data",  ifa.out_data,  0);
        chk("abort_busy",      busy_a,        0);
        chk("abort_checksum",  checksum_a,    0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        qa.delete();
        ifa.out_ready = 1'b1;
        push_scan(0);
        pulse_start_a();
        wait_done_a("restart_done_seen");
        chk("restart_checksum",    checksum_a, 32'h5D0);
        chk("restart_queue_empty", qa.size(),  0);

        // ---- halt detection ----
        @(posedge clock);
        #2 reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
`ifdef DEBUG_HALT_DETECT_EN
        push_scan(0);
`endif
        repeat (53) @(posedge clock);
        #1 instruction = HALT;
        @(posedge clock);
        #1 instruction = 32'd0;
`ifdef DEBUG_HALT_DETECT_EN
        chk("halt_instr_count", instr_count_a, 53);
        chk("halt_autostart",   busy_a,        1);
        wait_done_a("halt_done_seen");
        chk("halt_checksum",    checksum_a, 32'h5D0);
        chk("halt_queue_empty", qa.size(),  0);
        @(posedge clock);
        #1 instruction = HALT;
        repeat (3) begin
            @(posedge clock);
            #1 chk("halt_no_retrigger", busy_a, 0);
        end
        instruction = 32'd0;
        chk("halt_count_frozen", instr_count_a, 53);
`else
        chk("nohalt_busy", busy_a, 0);
        repeat (3) @(posedge clock);
        #1 chk("nohalt_busy_later", busy_a, 0);
        chk("nohalt_instr_count", instr_count_a, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
